// File: rtl/i2c_target_regs.sv
// i2c_target_regs
//   I2C target that exposes a byte-wide register file. The bus side supports
//   a pointer write followed by data writes with auto-increment, and
//   sequential reads from the pointer. A host-side port can also read and
//   write the same registers.
//
// Ports
//   clock       system clock
//   reset       asynchronous, active-low reset
//   scl_in      raw bus SCL
//   sda_in      raw bus SDA
//   sda_oe      1 = pull SDA low, 0 = release
//   host_addr   host register index (PTR_W bits)
//   host_we     host write strobe
//   host_wdata  host write data
//   host_rdata  regs[host_addr], combinational
//   wr_pulse    one-cycle pulse when a bus write commits
//   wr_idx      register index of the last bus write
//   busy        high from an address-matched START until STOP
//
// Build option
//   I2C_TGT_GLITCH_FILTER_EN  when defined, a synchronised line change is
//   accepted only after it has been stable for 3 clocks.
//
// FSM states
//   state     | meaning
//   IDLE      | waiting for START
//   ADDR      | shifting in the address byte
//   ADDR_ACK  | acknowledging our address
//   PTR       | shifting in the pointer byte
//   PTR_ACK   | acknowledging the pointer byte
//   WDATA     | shifting in a write data byte
//   WDATA_ACK | acknowledging a write data byte
//   RDATA     | shifting out a read data byte
//   RACK      | sampling the controller's ACK/NACK
//   IGNORE    | not addressed or NACKed, SDA released until START/STOP
module i2c_target_regs #(
  parameter logic [6:0] TGT_ADDR = 7'h49,
  parameter int         NUM_REGS = 16,
  localparam int        PTR_W    = $clog2(NUM_REGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] host_addr,
  input  logic             host_we,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_pulse,
  output logic [PTR_W-1:0] wr_idx,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  // Synchronisers, idle-high out of reset
  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic scl_f, sda_f;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  // Down-counter per line: reloads while the input matches the filtered
  // value, and the new level is taken once it has differed for 3 clocks.
  logic [1:0] scl_tmr, sda_tmr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_tmr <= 2'd2;
      sda_tmr <= 2'd2;
    end else begin
      if (scl_s2 == scl_f) begin
        scl_tmr <= 2'd2;
      end else if (scl_tmr == 2'd0) begin
        scl_f   <= scl_s2;
        scl_tmr <= 2'd2;
      end else begin
        scl_tmr <= scl_tmr - 2'd1;
      end
      if (sda_s2 == sda_f) begin
        sda_tmr <= 2'd2;
      end else if (sda_tmr == 2'd0) begin
        sda_f   <= sda_s2;
        sda_tmr <= 2'd2;
      end else begin
        sda_tmr <= sda_tmr - 2'd1;
      end
    end
  end
`else
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  // Edge and bus-condition detection
  logic scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

  // Register file
  logic [7:0] regs [NUM_REGS];

  state_t           state, state_d;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [6:0]       rx_sh, rx_sh_d;
  logic [6:0]       tx_sh, tx_sh_d;
  logic             rw, rw_d;
  logic             rd_load, rd_load_d;
  logic             sda_oe_d, busy_d;
  logic             commit;
  logic [7:0]       rx_byte, rd_byte;

  assign rx_byte    = {rx_sh, sda_f};
  assign rd_byte    = regs[ptr];
  assign host_rdata = regs[host_addr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      bit_cnt  <= 3'd7;
      rx_sh    <= '0;
      tx_sh    <= '0;
      rw       <= 1'b0;
      rd_load  <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_idx   <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      bit_cnt  <= bit_cnt_d;
      rx_sh    <= rx_sh_d;
      tx_sh    <= tx_sh_d;
      rw       <= rw_d;
      rd_load  <= rd_load_d;
      sda_oe   <= sda_oe_d;
      busy     <= busy_d;
      wr_pulse <= commit;
      if (commit) wr_idx <= ptr;
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    bit_cnt_d = bit_cnt;
    rx_sh_d   = rx_sh;
    tx_sh_d   = tx_sh;
    rw_d      = rw;
    rd_load_d = rd_load;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    commit    = 1'b0;
    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      rd_load_d = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd7;
      rd_load_d = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            rx_sh_d = rx_byte[6:0];
            if (bit_cnt != 3'd0) begin
              bit_cnt_d = bit_cnt - 3'd1;
            end else if (state == ADDR) begin
              if (rx_byte[7:1] == TGT_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
              end else begin
                state_d = IGNORE;
              end
            end else if (state == PTR) begin
              ptr_d   = rx_byte[PTR_W-1:0];
              state_d = PTR_ACK;
            end else begin
              commit  = 1'b1;
              ptr_d   = ptr + PTR_W'(1'b1);
              state_d = WDATA_ACK;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // sda_oe doubles as the phase flag: the first fall starts the
          // ACK, the second fall ends it.
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd7;
              if (state == ADDR_ACK && rw) begin
                state_d  = RDATA;
                tx_sh_d  = rd_byte[6:0];
                sda_oe_d = ~rd_byte[7];
              end else if (state == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (rd_load) begin
              rd_load_d = 1'b0;
              tx_sh_d   = rd_byte[6:0];
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = 3'd7;
            end else if (bit_cnt == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = RACK;
            end else begin
              sda_oe_d  = ~tx_sh[6];
              tx_sh_d   = {tx_sh[5:0], 1'b0};
              bit_cnt_d = bit_cnt - 3'd1;
            end
          end
        end
        RACK: begin
          // On ACK the next byte is fetched at the following SCL fall,
          // after the pointer has advanced.
          if (scl_rise) begin
            if (!sda_f) begin
              ptr_d     = ptr + PTR_W'(1'b1);
              rd_load_d = 1'b1;
              state_d   = RDATA;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus write is applied after the host write so it wins on the same index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      if (host_we) regs[host_addr] <= host_wdata;
      if (commit)  regs[ptr]       <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
module tb_i2c_target_regs;
  localparam int Q = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [3:0] host_addr = 4'd0;
  logic       host_we = 1'b0;
  logic [7:0] host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       wr_pulse;
  logic [3:0] wr_idx;
  logic       busy;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clock = ~clock;

  i2c_target_regs dut (
    .clock      (clock),
    .reset      (reset),
    .scl_in     (scl_m),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .host_addr  (host_addr),
    .host_we    (host_we),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_pulse   (wr_pulse),
    .wr_idx     (wr_idx),
    .busy       (busy)
  );

  typedef struct {
    logic [3:0] idx;
    logic [7:0] data;
  } wr_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model [16];
  logic [3:0] mptr = 4'd0;
  wr_t        wr_q [$];
  logic       ack_q [$];
  logic [7:0] rd_q [$];
  int         oe_cycles = 0;
  logic       wr_prev = 1'b0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input logic is_data,
                            input logic collide, input logic [3:0] h_idx, input logic [7:0] h_dat);
    logic got;
    logic seen;
    ack_q.push_back(exp_ack);
    if (is_data) begin
      wr_q.push_back('{idx: mptr, data: b});
      host_addr = collide ? h_idx : mptr;
      if (collide) begin
        host_wdata   = h_dat;
        model[h_idx] = h_dat;
      end
      model[mptr] = b;
      mptr = mptr + 4'd1;
    end
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wq();
      scl_m = 1'b1;
      if (collide && i == 0) begin
        host_we = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4 * Q && !seen; k++) begin
          @(negedge clock);
          seen = wr_pulse;
        end
        host_we = 1'b0;
        cmp("collide_commit_seen", seen, 1);
      end
      wq(); wq();
      scl_m = 1'b0; wq();
    end
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    got = ~sda_bus; wq();
    scl_m = 1'b0; wq();
    cmp("ack", got, ack_q.pop_front());
  endtask

  task automatic write_ptr(input logic [7:0] b);
    write_byte(b, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    mptr = b[3:0];
  endtask

  task automatic write_data(input logic [7:0] b);
    write_byte(b, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic read_byte(input logic ack);
    logic [7:0] got;
    rd_q.push_back(model[mptr]);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq();
      scl_m = 1'b1; wq();
      got[i] = sda_bus; wq();
      scl_m = 1'b0; wq();
    end
    sda_m = ack ? 1'b0 : 1'b1; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
    sda_m = 1'b1;
    if (ack) mptr = mptr + 4'd1;
    cmp("rdata", got, rd_q.pop_front());
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      #1;
      cmp(tag, host_rdata, model[i]);
    end
  endtask

  // Bus-write monitor: pops the expected commit each time wr_pulse fires
  always @(negedge clock) begin
    wr_t e;
    if (sda_oe) oe_cycles++;
    if (wr_pulse) begin
      cmp("wr_pulse_width", wr_prev, 0);
      n_cmp++;
      assert (wr_q.size() > 0) else begin
        n_bad++;
        $error("FAIL wr_unexpected: got pulse with wr_idx %0h expected no pulse", wr_idx);
      end
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        cmp("wr_idx", wr_idx, e.idx);
        if (host_addr == e.idx) cmp("rdata_after_commit", host_rdata, e.data);
      end
    end
    wr_prev = wr_pulse;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clock);
    cmp("rst_sda_oe", sda_oe, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_wr_pulse", wr_pulse, 0);
    cmp("rst_wr_idx", wr_idx, 0);
    reset = 1'b1;
    wq();
    check_regs("rst_regs");

    // Pointer + two data writes
    i2c_start();
    write_byte(8'h92, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    cmp("busy_after_match", busy, 1);
    write_ptr(8'h03);
    write_data(8'hAA);
    write_data(8'h55);
    i2c_stop();
    cmp("busy_after_stop", busy, 0);
    check_regs("wr_basic");

    // Pointer wrap
    i2c_start();
    write_byte(8'h92, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    write_ptr(8'h0F);
    write_data(8'h11);
    write_data(8'h22);
    i2c_stop();
    check_regs("wr_wrap");

    // Pointer write, repeated START, two reads (ACK then NACK)
    i2c_start();
    write_byte(8'h92, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    write_ptr(8'h04);
    i2c_start();
    write_byte(8'h93, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    read_byte(1'b1);
    read_byte(1'b0);
    cmp("oe_after_nack", sda_oe, 0);
    i2c_stop();

    // Address mismatch: no ACK, no drive, no writes
    n0 = oe_cycles;
    i2c_start();
    write_byte(8'hA0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    cmp("busy_mismatch", busy, 0);
    write_byte(8'h05, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    write_byte(8'h99, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    i2c_stop();
    cmp("oe_cycles_mismatch", oe_cycles - n0, 0);
    check_regs("regs_mismatch");

    // Host write colliding with bus commit: same index, then different index
    i2c_start();
    write_byte(8'h92, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    write_ptr(8'h05);
    write_byte(8'h33, 1'b1, 1'b1, 1'b1, 4'd5, 8'h77);
    write_byte(8'h44, 1'b1, 1'b1, 1'b1, 4'd9, 8'h66);
    i2c_stop();
    check_regs("regs_collide");

    // Reset while driving read data
    i2c_start();
    write_byte(8'h92, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    write_ptr(8'h05);
    i2c_start();
    write_byte(8'h93, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    cmp("oe_driving_msb", sda_oe, 1);
    #2;
    reset = 1'b0;
    #1;
    cmp("oe_async_release", sda_oe, 0);
    cmp("busy_async_reset", busy, 0);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    mptr = 4'd0;
    reset = 1'b1;
    wq();
    scl_m = 1'b1;
    wq();

    // Transaction after reset completes normally
    i2c_start();
    write_byte(8'h92, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    write_ptr(8'h08);
    write_data(8'h5A);
    i2c_stop();
    i2c_start();
    write_byte(8'h92, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    write_ptr(8'h08);
    i2c_start();
    write_byte(8'h93, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    read_byte(1'b0);
    i2c_stop();
    check_regs("regs_after_reset");

    wq();
    cmp("wr_q_drained", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter TGT_ADDR, default 7'h49, the 7-bit bus address this target answers to.
REQ-002 SHALL have parameter NUM_REGS, default 16, the register-file depth; legal values are powers of two from 2 to 256.
REQ-003 SHALL use local PTR_W = $clog2(NUM_REGS) as the pointer width.
REQ-004 clock  in  1  system clock; reset reset, asynchronous, active-low; clock clock.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 scl_in  in  1  raw bus SCL.
REQ-007 sda_in  in  1  raw bus SDA.
REQ-008 sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
REQ-009 host_addr  in  PTR_W  host-side register index.
REQ-010 host_we  in  1  host write strobe.
REQ-011 host_wdata  in  8  host write data.
REQ-012 host_rdata  out  8  regs[host_addr], combinational.
REQ-013 wr_pulse  out  1  one-cycle pulse when an I2C write commits.
REQ-014 wr_idx  out  PTR_W  index of the committed I2C write.
REQ-015 busy  out  1  high from an address-matched START until STOP.

Function
REQ-016 SHALL pass scl_in/sda_in through a 2-flop synchroniser and detect edges on the synchronised values only.
REQ-017 SHALL define START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high; both are recognised in every state.
REQ-018 SHALL implement the FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
REQ-019 SHALL go to ADDR on START from any state, which covers repeated START; the pointer is retained.
REQ-020 SHALL go to IDLE on STOP from any state, release sda_oe, and drop busy.
REQ-021 SHALL sample SDA MSB-first on SCL rise and complete a byte on the 8th rise.
REQ-022 Address byte:
- Bits [7:1] equal to TGT_ADDR: drive ACK.
- Otherwise: go to IGNORE, where sda_oe stays 0 until START or STOP.
REQ-023 ACK SHALL assert sda_oe from the SCL fall after bit 8 until the SCL fall after the 9th clock.
REQ-024 R/W bit = 0: the first data byte SHALL load the pointer with byte[PTR_W-1:0]; upper bits are ignored; ACK.
REQ-025 Each following write byte SHALL:
- be written to regs[ptr];
- pulse wr_pulse with wr_idx = ptr one cycle after the 8th rise;
- ACK;
- increment ptr modulo NUM_REGS (NUM_REGS-1 wraps to 0).
REQ-026 R/W bit = 1 (RDATA):
- Latch regs[ptr] at the ACK-ending SCL fall.
- Present the MSB on sda_oe = ~bit, changing only on SCL fall.
- Release SDA after bit 0.
REQ-027 RACK SHALL sample SDA on the 9th rise:
- Low (ACK): increment ptr with wrap and go to RDATA.
- High (NACK): go to IGNORE.
REQ-028 If host_we and an I2C commit hit the same index in the same cycle, the I2C data SHALL win; on different indices both writes SHALL occur.
REQ-029 host_rdata SHALL reflect an I2C write on the cycle after the commit.

Reset
REQ-030 On reset:
- state = IDLE, ptr = 0, all regs = 8'h00;
- sda_oe = 0, wr_pulse = 0, wr_idx = 0, busy = 0;
- synchronisers = 1 (bus idle high).
REQ-031 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); the target SHALL ignore the bus until the next START.

Configuration
REQ-032 Macro I2C_TGT_GLITCH_FILTER_EN:
- Defined: a synchronised line change SHALL be accepted only after it is stable for 3 consecutive clocks, which adds 3 cycles of latency.
- Undefined: the synchroniser output SHALL be used directly.

Verification
REQ-033 Write 0x92, 0x03, 0xAA, 0x55, STOP -> ACK on all 4 bytes; regs[3] = 0xAA, regs[4] = 0x55; wr_pulse twice with wr_idx 3 then 4.
REQ-034 Write 0x92, 0x0F, 0x11, 0x22 with NUM_REGS = 16 -> regs[15] = 0x11, regs[0] = 0x22 (wrap).
REQ-035 Write 0x92, 0x04; repeated START; 0x93; read 2 bytes (ACK, then NACK); STOP -> data 0x55, 0x00 on SDA; after NACK, sda_oe = 0.
REQ-036 Address 0xA0 (mismatch) -> sda_oe never asserts; busy = 0; regs unchanged.
REQ-037 host_we at index 5 with 0x77 in the same cycle as an I2C commit to index 5 of 0x33 -> regs[5] = 0x33.
REQ-038 Reset asserted during RDATA while sda_oe = 1 -> sda_oe = 0 immediately; the next transaction completes normally.
